// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port synchronous memory.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       if_req,
  input  logic [7:0] if_addr,
  output logic       if_gnt,
  output logic       if_rvalid,
  output logic [7:0] if_rdata,
  input  logic       dm_req,
  input  logic       dm_we,
  input  logic [7:0] dm_addr,
  input  logic [7:0] dm_wdata,
  output logic       dm_gnt,
  output logic       dm_rvalid,
  output logic [7:0] dm_rdata,
  output logic       mem_en,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT must be in 1..15");
  end

  logic       if_win, dm_win;
  logic       if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
  logic       mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [7:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic       pend_if_q, pend_if_d, pend_dm_q, pend_dm_d;
  logic       if_rvalid_q, if_rvalid_d, dm_rvalid_q, dm_rvalid_d;
  logic [7:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];
  logic       force_if;
  logic [3:0] starve_cnt_q, starve_cnt_d;
`endif

  always_comb begin
    dm_win = dm_req;
    if_win = if_req & ~dm_req;
`ifdef MEM_ARB_STARVE_GUARD_EN
    // Once fetch has lost LIMIT edges in a row it takes this edge unconditionally.
    force_if     = if_req && (starve_cnt_q == LIMIT);
    dm_win       = dm_req & ~force_if;
    if_win       = if_req & ~dm_win;
    starve_cnt_d = starve_cnt_q;
    if (!if_req || if_win)
      starve_cnt_d = '0;
    else if (dm_win)
      starve_cnt_d = starve_cnt_q + 4'd1;
`endif
  end

  always_comb begin
    if_gnt_d    = if_win;
    dm_gnt_d    = dm_win;
    mem_en_d    = if_win | dm_win;
    mem_we_d    = dm_win & dm_we;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (dm_win) begin
      mem_addr_d  = dm_addr;
      mem_wdata_d = dm_wdata;
    end else if (if_win) begin
      mem_addr_d  = if_addr;
    end
    // Owner tag rides one stage behind the grant; memory data arrives during that stage.
    pend_if_d   = if_gnt_q;
    pend_dm_d   = dm_gnt_q & ~mem_we_q;
    if_rvalid_d = pend_if_q;
    dm_rvalid_d = pend_dm_q;
    if_rdata_d  = pend_if_q ? mem_rdata : if_rdata_q;
    dm_rdata_d  = pend_dm_q ? mem_rdata : dm_rdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pend_if_q   <= 1'b0;
      pend_dm_q   <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      starve_cnt_q <= '0;
`endif
    end else begin
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      pend_if_q   <= pend_if_d;
      pend_dm_q   <= pend_dm_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
`ifdef MEM_ARB_STARVE_GUARD_EN
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  assign if_gnt    = if_gnt_q;
  assign dm_gnt    = dm_gnt_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, 3, consecutive fetch-denied cycles before fetch is forced to win (range 1..15).
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch-unit read request.
- if_addr  in  8  fetch address (PC).
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  8  fetch read data.
- dm_req  in  1  data/stack-port request.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  8  data address.
- dm_wdata  in  8  write data.
- dm_gnt  out  1  data request accepted this cycle.
- dm_rvalid  out  1  data read valid (reads only).
- dm_rdata  out  8  data read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  8  memory address.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  synchronous memory read data, valid the cycle after mem_en.

Function
REQ-003 SHALL arbitrate at every rising edge among asserted requests and grant at most one.
REQ-004 Grant outputs SHALL be registered: winner's gnt, mem_en=1, mem_we, mem_addr, mem_wdata all asserted together for exactly one cycle after the deciding edge.
REQ-005 No request at an edge SHALL give mem_en=0, mem_we=0, both gnt=0 next cycle; mem_addr/mem_wdata hold last value.
REQ-006 Requesters hold req/addr/we/wdata stable until gnt; req still high during the gnt cycle SHALL count as a new request (back-to-back grant every cycle allowed).
REQ-007 Default priority SHALL be dm over if when both request.
REQ-008 Read pipeline: owner tag SHALL follow the access; mem_rdata SHALL be registered into owner's rdata with owner's rvalid high for one cycle, exactly 2 cycles after its gnt cycle start (gnt at cycle N -> rvalid at N+2).
REQ-009 Writes SHALL produce no rvalid; pipeline SHALL sustain one access per cycle with rvalids in grant order.
REQ-010 if_rdata/dm_rdata SHALL hold their last value when rvalid=0.
REQ-011 Read following write to same address in consecutive grants SHALL return the written data (single port, in-order).
REQ-012 Fetch never writes memory; mem_we SHALL be 0 on every fetch grant.

Reset
REQ-013 reset=0 SHALL asynchronously clear all gnt, rvalid, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, owner tags, and the starvation counter to 0.
REQ-014 Reset mid-operation SHALL discard in-flight reads: no rvalid after reset release for accesses granted before it.
REQ-015 First arbitration SHALL occur at the first rising edge with reset=1.

Configuration
REQ-016 Macro MEM_ARB_STARVE_GUARD_EN defined: 4-bit counter increments each edge where if_req=1 and dm wins; when counter == STARVE_LIMIT, fetch SHALL win that edge regardless of dm_req; counter clears on fetch grant or if_req=0.
REQ-017 Macro undefined: strict dm-over-if priority, no counter logic; fetch may starve indefinitely.

Verification
REQ-018 Single fetch: if_req=1, if_addr=0x10, mem holds 0x00 at 0x10 -> if_gnt and mem_addr=0x10 next cycle, if_rvalid with if_rdata=0x00 two cycles later.
REQ-019 Contention: if_req and dm_req (read 0xAA) same edge -> dm_gnt first, if_gnt next cycle; rvalids in same order.
REQ-020 Write then read: dm write 0x55 to 0x30, then dm read 0x30 back-to-back -> dm_rvalid once, dm_rdata=0x55; no rvalid for the write.
REQ-021 Starvation (macro defined, STARVE_LIMIT=3): dm_req held high with if_req high -> 3 dm grants, 4th grant to fetch, then dm resumes; macro undefined -> fetch never granted.
REQ-022 Reset abort: assert reset one cycle after dm read gnt -> all outputs 0 immediately, no dm_rvalid after release.
